lift_sequencer: RTL
===================

# lift_sequencer

Cycle-level controller for the six-floor lift car datapath. It latches floor requests, picks a direction with a SCAN policy (keep going while requests remain ahead), and drives the car's MoveUp/MoveDown/OpenDoor/CloseDoor/stop commands. It also generates the car's `done` strobe from its `start` output via an internal step timer. It sits between the floor/car button logic and the lift car, and is the only master of the car's command inputs.

## Interface
- FLOORS, 6, number of floors; equals the width of Sensor and req
- TRAVEL_CYCLES, 8, cycles of car `start` per one-floor move (≥2)
- DOOR_CYCLES, 4, cycles of car `start` per door-open operation (≥2)
- DWELL_CYCLES, 16, cycles the door is held open after opening completes (≥1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- req  in  FLOORS  floor request bits, level or pulse, OR-ed into pending
- Sensor  in  FLOORS  one-hot car position from the car
- start  in  1  car busy flag
- Passenger_in  in  1  car door-open-complete flag, used for status only
- done  out  1  step-complete strobe to the car
- MoveUp, MoveDown, OpenDoor, CloseDoor, stop  out  1 each  car commands
- pending  out  FLOORS  outstanding requests
- dir_up  out  1  current SCAN direction
- busy  out  1  state ≠ IDLE
- fault  out  1  sticky flag: Sensor was not one-hot

## Operation
- The clock is one clock, `clk`. Reset is synchronous and active-high, named `reset`.
- Reset values: MoveUp=MoveDown=OpenDoor=CloseDoor=0, stop=1, done=0, pending=0, dir_up=1, busy=0, fault=0. State=IDLE and the timer count is 0.
- Reset mid-operation clears all state. Car position is retained through Sensor.
- pending ← (pending | req) & ~clear. When clear and set hit the same bit in the same cycle, clear wins only for the current floor in DWELL.
- Masks: above = ~(Sensor | (Sensor−1)); below = Sensor−1. Arithmetic is FLOORS bits wide, with wrap discarded.
- Outputs are Moore-decoded from state:
  - MOVE: stop=0, MoveUp=dir_up, MoveDown=~dir_up.
  - OPEN: stop=1, OpenDoor=1.
  - CLOSE: stop=1, CloseDoor=1.
  - All other states: stop=1 and all commands 0.
- States and transitions:
  - IDLE:
    - If pending & Sensor is set → OPEN.
    - Otherwise, if there are pending requests ahead in dir_up → MOVE.
    - Otherwise, if there are pending requests behind → flip dir_up, then MOVE.
    - Otherwise stay in IDLE.
  - MOVE: on done (and start=1), the car shifts Sensor at the same edge → STEP.
  - STEP: one cycle with all commands low, so the car does not restart. Evaluate as in IDLE using the new Sensor.
  - OPEN: on done → DWELL. Clear pending for the current floor on entry.
  - DWELL: count DWELL_CYCLES → CLOSE. A new req for the current floor restarts the dwell count and is absorbed.
  - CLOSE: one cycle → IDLE.
  - FAULT: entered from any state when Sensor is not one-hot. All commands are 0, stop=1, fault=1, until reset.
- dir_up never points past an end floor. The move condition requires a pending request in that direction.

## Timing
- Timer (lift_timer):
  - Enable = start & (state ∈ {MOVE, OPEN}).
  - Limit N = TRAVEL_CYCLES when stop=0, else DOOR_CYCLES.
  - done = enable & (cnt == N−1), combinational from the registered cnt.
  - cnt ← (enable & ~done) ? cnt+1 : 0.
  - done is therefore high in the N-th cycle of start.
- Request latency: req sampled at edge t sets pending at t. IDLE leaves at edge t+1, so MoveUp/MoveDown/OpenDoor are high from cycle t+1.
- One-floor move:
  - MoveUp is high for TRAVEL_CYCLES+1 cycles; start follows one cycle later.
  - Sensor shifts on the done edge, then STEP follows for 1 cycle.
- Door cycle:
  - OpenDoor is high for DOOR_CYCLES+1 cycles.
  - DWELL lasts DWELL_CYCLES cycles.
  - CloseDoor is high for 1 cycle.
- Status: Passenger_in rises at the OPEN→DWELL edge.

## Structure
- Package lift_pkg holds:
  - the state enum (IDLE, MOVE, STEP, OPEN, DWELL, CLOSE, FAULT)
  - the FLOORS default
  - the one-hot check function
- Sub-module lift_timer: start/enable/limit in, done out, with clog2(max(TRAVEL_CYCLES, DOOR_CYCLES)) counter width.
- lift_sequencer instantiates lift_timer and is connected to the car in the top-level bench.

## Test plan
- Reset, car at floor 0 (Sensor=000001), pulse req=001000 → MoveUp pulses three times, Sensor=001000 → OpenDoor, pending clears, dwell 16 cycles, CloseDoor, then IDLE with pending=0.
- Car at floor 2, dir_up=1, req=100001 simultaneously → car serves floor 5 first, then flips dir_up=0 and serves floor 0.
- Car at floor 3, req=001000 → no movement; OpenDoor within 1 cycle of pending set, and MoveUp/MoveDown stay 0 throughout.
- During DWELL at floor 3, req=001000 again → dwell count restarts, CloseDoor is delayed by the elapsed cycles, pending stays 0.
- Reset asserted mid-MOVE → next cycle all commands 0, stop=1, pending=0, state IDLE, and Sensor is unchanged.
- Force Sensor=000011 → fault=1 and all commands 0 the next cycle; the fault holds until reset.

Source files
------------

// File: rtl/lift_pkg.sv
`default_nettype none
// ============================================================================
// Package  : lift_pkg
// Brief    : Shared state type, default floor count and one-hot helper.
// Revision : 1.0 - initial release
// ============================================================================
package lift_pkg;

    localparam int c_FLOORS_DEFAULT = 6;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MOVE  = 3'd1,
        STEP  = 3'd2,
        OPEN  = 3'd3,
        DWELL = 3'd4,
        CLOSE = 3'd5,
        FAULT = 3'd6
    } lift_state_t;

    // Callers zero-extend their vector; supports up to 32 floors.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lift_if.sv
`default_nettype none
// ============================================================================
// Interface: lift_if
// Brief    : Command/status bundle between the sequencer and the lift car.
// Revision : 1.0 - initial release
// ============================================================================
interface lift_if
    import lift_pkg::*;
#(
    parameter int FLOORS = c_FLOORS_DEFAULT
);
    logic [FLOORS-1:0] Sensor;
    logic              start;
    logic              Passenger_in;
    logic              done;
    logic              MoveUp;
    logic              MoveDown;
    logic              OpenDoor;
    logic              CloseDoor;
    logic              stop;

    modport master (
        input  Sensor, start, Passenger_in,
        output done, MoveUp, MoveDown, OpenDoor, CloseDoor, stop
    );

    modport slave (
        output Sensor, start, Passenger_in,
        input  done, MoveUp, MoveDown, OpenDoor, CloseDoor, stop
    );
endinterface
`default_nettype wire

// File: rtl/lift_timer.sv
`default_nettype none
// ============================================================================
// Module   : lift_timer
// Brief    : Counts cycles of car start and strobes done in the limit-th one.
// Revision : 1.0 - initial release
// ============================================================================
module lift_timer #(
    parameter int CNT_W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         enable,
    input  logic [CNT_W:0] limit,
    output logic         done
);
    logic [CNT_W-1:0] r_cnt;
    logic             w_run;
    logic [CNT_W:0]   w_last;

    assign w_run  = start & enable;
    assign w_last = limit - (CNT_W + 1)'(1);
    assign done   = w_run & ({1'b0, r_cnt} == w_last);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_run & ~done) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end
endmodule
`default_nettype wire

// File: rtl/lift_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lift_sequencer
// Brief    : SCAN-policy lift controller driving car commands and done strobe.
// Revision : 1.0 - initial release
// ============================================================================
module lift_sequencer
    import lift_pkg::*;
#(
    parameter int FLOORS        = c_FLOORS_DEFAULT,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4,
    parameter int DWELL_CYCLES  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-1:0] req,
    lift_if.master            car,
    output logic [FLOORS-1:0] pending,
    output logic              dir_up,
    output logic              busy,
    output logic              fault
);
    localparam int c_TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int c_CW   = $clog2(c_TMAX);
    localparam int c_DW   = $clog2(DWELL_CYCLES + 1);
    localparam logic [c_DW-1:0] c_DWELL_LAST = c_DW'(DWELL_CYCLES - 1);

    lift_state_t       r_state, w_state_nxt;
    logic [FLOORS-1:0] r_pending, w_pending_nxt;
    logic              r_dir_up, w_dir_nxt;
    logic [c_DW-1:0]   r_dwell, w_dwell_nxt;

    logic [FLOORS-1:0] w_below, w_above, w_here, w_ahead, w_behind;
    logic              w_reopen, w_sensor_ok, w_enter_open;
    logic              w_stop, w_move_up, w_move_dn, w_open, w_close;
    logic              w_timer_en, w_done;
    logic [c_CW:0]     w_limit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_dir_up  <= 1'b1;
            r_dwell   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_dir_up  <= w_dir_nxt;
            r_dwell   <= w_dwell_nxt;
        end
    end

    // Floor masks relative to the car: everything strictly above / below it.
    always_comb begin
        w_below     = car.Sensor - FLOORS'(1);
        w_above     = ~(car.Sensor | w_below);
        w_here      = r_pending & car.Sensor;
        w_ahead     = r_pending & (r_dir_up ? w_above : w_below);
        w_behind    = r_pending & (r_dir_up ? w_below : w_above);
        w_reopen    = |(req & car.Sensor);
        w_sensor_ok = is_onehot(32'(car.Sensor));
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir_up;
        w_dwell_nxt = r_dwell;
        unique case (r_state)
            IDLE, STEP: begin
                if (|w_here) begin
                    w_state_nxt = OPEN;
                end else if (|w_ahead) begin
                    w_state_nxt = MOVE;
                end else if (|w_behind) begin
                    w_dir_nxt   = ~r_dir_up;
                    w_state_nxt = MOVE;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            MOVE: begin
                if (w_done) w_state_nxt = STEP;
            end
            OPEN: begin
                if (w_done) begin
                    w_state_nxt = DWELL;
                    w_dwell_nxt = '0;
                end
            end
            DWELL: begin
                // A fresh call for this floor keeps the door open longer.
                if (w_reopen) begin
                    w_dwell_nxt = '0;
                end else if (r_dwell == c_DWELL_LAST) begin
                    w_dwell_nxt = '0;
                    w_state_nxt = CLOSE;
                end else begin
                    w_dwell_nxt = r_dwell + c_DW'(1);
                end
            end
            CLOSE:   w_state_nxt = IDLE;
            FAULT:   w_state_nxt = FAULT;
            default: w_state_nxt = IDLE;
        endcase
        if (!w_sensor_ok) w_state_nxt = FAULT;
    end

    always_comb begin
        w_enter_open = (w_state_nxt == OPEN) && (r_state != OPEN);
        if (r_state == DWELL) begin
            w_pending_nxt = (r_pending | req) & ~car.Sensor;
        end else if (w_enter_open) begin
            w_pending_nxt = (r_pending & ~car.Sensor) | req;
        end else begin
            w_pending_nxt = r_pending | req;
        end
    end

    always_comb begin
        w_stop    = 1'b1;
        w_move_up = 1'b0;
        w_move_dn = 1'b0;
        w_open    = 1'b0;
        w_close   = 1'b0;
        unique case (r_state)
            MOVE: begin
                w_stop    = 1'b0;
                w_move_up = r_dir_up;
                w_move_dn = ~r_dir_up;
            end
            OPEN:    w_open  = 1'b1;
            CLOSE:   w_close = 1'b1;
            default: ;
        endcase
        w_timer_en = (r_state == MOVE) || (r_state == OPEN);
        w_limit    = w_stop ? (c_CW + 1)'(DOOR_CYCLES) : (c_CW + 1)'(TRAVEL_CYCLES);
    end

    lift_timer #(
        .CNT_W (c_CW)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .start  (car.start),
        .enable (w_timer_en),
        .limit  (w_limit),
        .done   (w_done)
    );

    assign car.done      = w_done;
    assign car.MoveUp    = w_move_up;
    assign car.MoveDown  = w_move_dn;
    assign car.OpenDoor  = w_open;
    assign car.CloseDoor = w_close;
    assign car.stop      = w_stop;

    assign pending = r_pending;
    assign dir_up  = r_dir_up;
    assign busy    = (r_state != IDLE);
    assign fault   = (r_state == FAULT);
endmodule
`default_nettype wire
